// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: walks pc over a synchronous ROM and feeds the Datapath
// through a 2-entry skid buffer. Build macro IFU_LOOP_EN wraps pc at PROG_LEN and fetches forever.
//
// state   | meaning
// S_IDLE  | waiting for start (after reset or halt)
// S_FETCH | issuing ROM reads while buffer credit allows
// S_DRAIN | every read issued, emptying buffer and in-flight word
// S_DONE  | run complete, done held high
module instr_fetch_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W:0]   pc,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(PROG_LEN);
`ifdef IFU_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d, pc_inc;
    logic              rd_en;
    logic              in_flight_q;
    logic              head_v_q, skid_v_q;
    logic [DATA_W-1:0] head_q, skid_q;
    logic              push, pop, credit_ok;
    logic [1:0]        occ;

    assign pc_inc = pc_q + 1'b1;
    assign pop    = head_v_q && instr_ready;
    assign push   = in_flight_q;
    // Occupancy counts the word still in flight so returning data always has a slot.
    assign occ       = 2'(head_v_q) + 2'(skid_v_q) + 2'(in_flight_q);
    assign credit_ok = (occ < 2'd2) || (pop && occ == 2'd2);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = (LOOP_EN || LEN != '0) ? S_FETCH : S_DRAIN;
                end
            end
            S_FETCH: begin
                if (pc_q < LEN && credit_ok) begin
                    rd_en = 1'b1;
                    pc_d  = pc_inc;
                    if (pc_inc == LEN) begin
                        if (LOOP_EN) pc_d = '0;
                        else         state_d = S_DRAIN;
                    end
                end else if (!LOOP_EN && pc_q >= LEN) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!head_v_q && !skid_v_q && !in_flight_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // halt wins over start and suppresses the read in the same cycle
        if (halt) begin
            state_d = S_IDLE;
            pc_d    = pc_q;
            rd_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // head_q doubles as the instr register, so it keeps its last value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= 1'b0;
            head_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
        end else if (halt) begin
            in_flight_q <= 1'b0;
            head_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
        end else begin
            in_flight_q <= rd_en;
            case ({pop, push})
                2'b01: begin
                    if (!head_v_q) begin
                        head_q   <= imem_rdata;
                        head_v_q <= 1'b1;
                    end else begin
                        skid_q   <= imem_rdata;
                        skid_v_q <= 1'b1;
                    end
                end
                2'b10: begin
                    if (skid_v_q) begin
                        head_q   <= skid_q;
                        skid_v_q <= 1'b0;
                    end else begin
                        head_v_q <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skid_v_q) begin
                        head_q <= skid_q;
                        skid_q <= imem_rdata;
                    end else begin
                        head_q <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_rd_en  = rd_en;
    assign imem_addr   = pc_q[ADDR_W-1:0];
    assign instr       = head_q;
    assign instr_valid = head_v_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: ROM[i] = 0xA0000000 + i, expected words queued at each
// start and consumed by a monitor on every valid/ready transfer. Honours IFU_LOOP_EN if defined.
module tb_instr_fetch_unit;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          PROG_LEN = 20;
    localparam logic [31:0] BASE     = 32'hA000_0000;
`ifdef IFU_LOOP_EN
    localparam int          N_PUSH   = PROG_LEN * 3;
`else
    localparam int          N_PUSH   = PROG_LEN;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              halt = 1'b0;
    logic              instr_ready = 1'b0;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W:0]   pc;
    logic              busy, done;

    logic              z_start = 1'b0;
    logic              z_halt = 1'b0;
    logic              z_rd_en;
    logic [ADDR_W-1:0] z_addr;
    logic [DATA_W-1:0] z_rdata;
    logic [DATA_W-1:0] z_instr;
    logic              z_valid;
    logic [ADDR_W:0]   z_pc;
    logic              z_busy, z_done;
    assign z_rdata = '0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          run_xfers = 0;
    logic [31:0] last_xfer = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic        prev_stall = 1'b0;
    logic        prev_halt = 1'b0;

    instr_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .busy(busy), .done(done)
    );

    instr_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(z_start), .halt(z_halt),
        .imem_rd_en(z_rd_en), .imem_addr(z_addr), .imem_rdata(z_rdata),
        .instr(z_instr), .instr_valid(z_valid), .instr_ready(instr_ready),
        .pc(z_pc), .busy(z_busy), .done(z_done)
    );

    always #5 clk = ~clk;

    // synchronous ROM: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= BASE + 32'(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // monitor: head word must always be the next expected word; pop on transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && !prev_halt) check("hold_valid", 32'(instr_valid), 32'd1);
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("xfer_extra", 32'(instr_valid), 32'd0);
                end else begin
                    check("head_data", instr, exp_q[0]);
                    if (instr_ready) begin
                        exp_w = exp_q.pop_front();
                        last_xfer = instr;
                        run_xfers++;
                    end
                end
            end
        end
        prev_stall = rst_n && instr_valid && !instr_ready;
        prev_halt  = halt;
    end

    task automatic push_expected();
        for (int i = 0; i < N_PUSH; i++) exp_q.push_back(BASE + 32'(i % PROG_LEN));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        run_xfers = 0;
        push_expected();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    32'(pc), 32'd0);
        check({tag, "_rd_en"}, 32'(imem_rd_en), 32'd0);
        check({tag, "_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    task automatic finish_run(input string tag, input int budget);
        int k = 0;
`ifdef IFU_LOOP_EN
        while (run_xfers < PROG_LEN && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        check({tag, "_xfers"}, 32'(run_xfers >= PROG_LEN), 32'd1);
        check({tag, "_no_done"}, 32'(done), 32'd0);
        halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        exp_q.delete();
        check({tag, "_halt_busy"}, 32'(busy), 32'd0);
`else
        while (!done && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        check({tag, "_done"},   32'(done), 32'd1);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_valid"},  32'(instr_valid), 32'd0);
        check({tag, "_last"},   instr, BASE + 32'(PROG_LEN - 1));
        check({tag, "_xfers"},  32'(run_xfers), 32'(PROG_LEN));
        check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        logic found;
        logic seen_rd, seen_v;
        void'($urandom(32'd20240611));

        // reset asserted between edges clears everything immediately
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;

        // latency and full-rate streaming
        @(posedge clk);
        #1 start = 1'b1;
        run_xfers = 0;
        push_expected();
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("lat_rd_en", 32'(imem_rd_en), 32'd1);
        check("lat_addr", 32'(imem_addr), 32'd0);
        check("lat_valid0", 32'(instr_valid), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_valid1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("lat_valid2", 32'(instr_valid), 32'd1);
        for (int i = 0; i < PROG_LEN; i++) begin
            check("stream_gap", 32'(instr_valid), 32'd1);
            @(negedge clk);
        end
        finish_run("t2", 20);

        // backpressure while 0xA0000003 is at the head
        pulse_start();
        k = 0;
        found = 1'b0;
        while (!found && k < 100) begin
            @(posedge clk);
            #2;
            if (instr_valid && instr == BASE + 32'd3) found = 1'b1;
            k++;
        end
        check("bp_reach", 32'(found), 32'd1);
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_instr", instr, BASE + 32'd3);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_rd_en", 32'(imem_rd_en), 32'd0);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        finish_run("t3", 60);

        // random ready, with a stray start pulse mid-run
        pulse_start();
        k = 0;
        while (run_xfers < PROG_LEN && k < 600) begin
            @(posedge clk);
            #1 instr_ready = 1'($urandom_range(0, 1));
            start = (k == 6);
            k++;
        end
        start = 1'b0;
        instr_ready = 1'b1;
        finish_run("t4", 40);

        // halt right after 0xA0000007 is taken
        pulse_start();
        last_xfer = '1;
        k = 0;
        while (last_xfer != BASE + 32'd7 && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("halt_reach", last_xfer, BASE + 32'd7);
        halt = 1'b1;
        #1 check("halt_rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clk);
        #1 halt = 1'b0;
        exp_q.delete();
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_done", 32'(done), 32'd0);
        // 8 words taken, 1 buffered and 1 in flight when halted
        check("halt_pc", 32'(pc), 32'd10);
        repeat (3) @(posedge clk);
        #1 check("halt_pc_hold", 32'(pc), 32'd10);
        pulse_start();
        finish_run("t5", 60);

        // reset during a run at index 10, then a clean restart
        pulse_start();
        k = 0;
        while (run_xfers < 10 && k < 100) begin
            @(posedge clk);
            #1 k++;
        end
        check("rst_reach", 32'(run_xfers), 32'd10);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        finish_run("t1b", 60);

`ifdef IFU_LOOP_EN
        // continuous wrap: scoreboard holds three passes of the program
        pulse_start();
        k = 0;
        while (!instr_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 2 * PROG_LEN + 5; c++) begin
            check("loop_gap", 32'(instr_valid), 32'd1);
            check("loop_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 halt = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        exp_q.delete();
        check("loop_halt_busy", 32'(busy), 32'd0);
`else
        // PROG_LEN = 0: straight to done, no reads, no valid
        @(posedge clk);
        #1 z_start = 1'b1;
        @(posedge clk);
        #1 z_start = 1'b0;
        @(negedge clk);
        seen_rd = z_rd_en;
        seen_v  = z_valid;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (z_rd_en) seen_rd = 1'b1;
            if (z_valid) seen_v = 1'b1;
        end
        check("zero_rd_en", 32'(seen_rd), 32'd0);
        check("zero_valid", 32'(seen_v), 32'd0);
        check("zero_done", 32'(z_done), 32'd1);
        check("zero_busy", 32'(z_busy), 32'd0);
        check("zero_pc", 32'(z_pc), 32'd0);
        check("zero_addr", 32'(z_addr), 32'd0);
        check("zero_instr", z_instr, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
